// File: rtl/rob_walk_ctrl.sv
// Spec-RAT recovery sequencer: one rollback cycle, then replays ROB entries head..flush, two per cycle.
// Optional ROB_WALK_PERF_EN adds saturating walk_cycle_cnt / flush_cnt outputs.
module rob_walk_ctrl #(
    parameter int ROB_DEPTH = 64,
    parameter int ROB_IDX_W = 6,
    parameter int ROB_PTR_W = 7,
    parameter int LREG_W    = 5,
    parameter int PREG_W    = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush_valid,
    input  logic [ROB_PTR_W-1:0] flush_robptr,
    input  logic [ROB_PTR_W-1:0] rob_head_ptr,
    output logic [ROB_IDX_W-1:0] walk2rob_rdaddr0,
    output logic [ROB_IDX_W-1:0] walk2rob_rdaddr1,
    input  logic [LREG_W-1:0]    rob2walk_lrd0,
    input  logic [LREG_W-1:0]    rob2walk_lrd1,
    input  logic [PREG_W-1:0]    rob2walk_prd0,
    input  logic [PREG_W-1:0]    rob2walk_prd1,
    input  logic                 rob2walk_need_to_wb0,
    input  logic                 rob2walk_need_to_wb1,
`ifdef ROB_WALK_PERF_EN
    output logic [31:0]          walk_cycle_cnt,
    output logic [31:0]          flush_cnt,
`endif
    output logic                 is_idle,
    output logic                 is_rollingback,
    output logic                 is_walking,
    output logic                 walking_valid0,
    output logic                 walking_valid1,
    output logic [LREG_W-1:0]    walking_lrd0,
    output logic [LREG_W-1:0]    walking_lrd1,
    output logic [PREG_W-1:0]    walking_prd0,
    output logic [PREG_W-1:0]    walking_prd1,
    output logic                 walk_busy,
    output logic                 walk_done
);

    // One-hot encoding so the state outputs are direct flop bits.
    typedef enum logic [2:0] {
        S_IDLE     = 3'b001,
        S_ROLLBACK = 3'b010,
        S_WALK     = 3'b100
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [ROB_PTR_W-1:0] r_walk_ptr;
    logic [ROB_PTR_W-1:0] r_walk_remain;
    logic                 r_walk_done;
    logic [ROB_PTR_W-1:0] w_step;
    logic                 w_accept;
    logic                 w_last;
    logic [ROB_IDX_W-1:0] w_idx1;

    assign is_idle        = r_state[0];
    assign is_rollingback = r_state[1];
    assign is_walking     = r_state[2];
    assign walk_busy      = ~is_idle;
    assign walk_done      = r_walk_done;

    assign w_accept = is_idle & flush_valid;
    assign w_last   = is_walking & (r_walk_remain <= ROB_PTR_W'(2));
    assign w_step   = (r_walk_remain >= ROB_PTR_W'(2)) ? ROB_PTR_W'(2) : r_walk_remain;
    assign w_idx1   = ROB_IDX_W'((32'(r_walk_ptr[ROB_IDX_W-1:0]) + 32'd1) % ROB_DEPTH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (flush_valid) w_state_nxt = S_ROLLBACK;
            S_ROLLBACK: w_state_nxt = S_WALK;
            S_WALK:     if (w_last) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // remain spans 1..ROB_DEPTH: the flushing instruction itself is always walked.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_walk_ptr    <= '0;
            r_walk_remain <= '0;
            r_walk_done   <= 1'b0;
        end else begin
            r_walk_done <= w_last;
            if (w_accept) begin
                r_walk_ptr    <= rob_head_ptr;
                r_walk_remain <= flush_robptr - rob_head_ptr + ROB_PTR_W'(1);
            end else if (is_walking) begin
                r_walk_ptr    <= r_walk_ptr + w_step;
                r_walk_remain <= r_walk_remain - w_step;
            end
        end
    end

    assign walk2rob_rdaddr0 = is_walking ? r_walk_ptr[ROB_IDX_W-1:0] : '0;
    assign walk2rob_rdaddr1 = is_walking ? w_idx1 : '0;

    assign walking_valid0 = is_walking & (r_walk_remain >= ROB_PTR_W'(1)) & rob2walk_need_to_wb0;
    assign walking_valid1 = is_walking & (r_walk_remain >= ROB_PTR_W'(2)) & rob2walk_need_to_wb1;

    assign walking_lrd0 = walking_valid0 ? rob2walk_lrd0 : '0;
    assign walking_prd0 = walking_valid0 ? rob2walk_prd0 : '0;
    assign walking_lrd1 = walking_valid1 ? rob2walk_lrd1 : '0;
    assign walking_prd1 = walking_valid1 ? rob2walk_prd1 : '0;

`ifdef ROB_WALK_PERF_EN
    logic [31:0] r_walk_cycle_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_walk_cycle_cnt <= '0;
            r_flush_cnt      <= '0;
        end else begin
            if (walk_busy && (r_walk_cycle_cnt != 32'hFFFF_FFFF)) r_walk_cycle_cnt <= r_walk_cycle_cnt + 32'd1;
            if (w_accept && (r_flush_cnt != 32'hFFFF_FFFF))       r_flush_cnt      <= r_flush_cnt + 32'd1;
        end
    end

    assign walk_cycle_cnt = r_walk_cycle_cnt;
    assign flush_cnt      = r_flush_cnt;
`endif

endmodule

// File: tb/tb_rob_walk_ctrl.sv
// Directed bench for rob_walk_ctrl: a stub ROB returns address-derived lrd/prd and a need_to_wb mask.
module tb_rob_walk_ctrl;

    logic       clock;
    logic       reset_n;
    logic       flush_valid;
    logic [6:0] flush_robptr;
    logic [6:0] rob_head_ptr;
    logic [5:0] walk2rob_rdaddr0, walk2rob_rdaddr1;
    logic [4:0] rob2walk_lrd0, rob2walk_lrd1;
    logic [5:0] rob2walk_prd0, rob2walk_prd1;
    logic       rob2walk_need_to_wb0, rob2walk_need_to_wb1;
    logic       is_idle, is_rollingback, is_walking;
    logic       walking_valid0, walking_valid1;
    logic [4:0] walking_lrd0, walking_lrd1;
    logic [5:0] walking_prd0, walking_prd1;
    logic       walk_busy, walk_done;
`ifdef ROB_WALK_PERF_EN
    logic [31:0] walk_cycle_cnt, flush_cnt;
`endif

    logic [63:0] mask;
    int checks;
    int failures;

    rob_walk_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .flush_valid(flush_valid), .flush_robptr(flush_robptr), .rob_head_ptr(rob_head_ptr),
        .walk2rob_rdaddr0(walk2rob_rdaddr0), .walk2rob_rdaddr1(walk2rob_rdaddr1),
        .rob2walk_lrd0(rob2walk_lrd0), .rob2walk_lrd1(rob2walk_lrd1),
        .rob2walk_prd0(rob2walk_prd0), .rob2walk_prd1(rob2walk_prd1),
        .rob2walk_need_to_wb0(rob2walk_need_to_wb0), .rob2walk_need_to_wb1(rob2walk_need_to_wb1),
`ifdef ROB_WALK_PERF_EN
        .walk_cycle_cnt(walk_cycle_cnt), .flush_cnt(flush_cnt),
`endif
        .is_idle(is_idle), .is_rollingback(is_rollingback), .is_walking(is_walking),
        .walking_valid0(walking_valid0), .walking_valid1(walking_valid1),
        .walking_lrd0(walking_lrd0), .walking_lrd1(walking_lrd1),
        .walking_prd0(walking_prd0), .walking_prd1(walking_prd1),
        .walk_busy(walk_busy), .walk_done(walk_done)
    );

    always #5 clock = ~clock;

    // Stub ROB contents, a fixed function of the entry index.
    function automatic logic [4:0] m_lrd(input logic [5:0] a);
        return a[4:0] ^ 5'h0A;
    endfunction
    function automatic logic [5:0] m_prd(input logic [5:0] a);
        return a + 6'd17;
    endfunction

    assign rob2walk_lrd0        = m_lrd(walk2rob_rdaddr0);
    assign rob2walk_lrd1        = m_lrd(walk2rob_rdaddr1);
    assign rob2walk_prd0        = m_prd(walk2rob_rdaddr0);
    assign rob2walk_prd1        = m_prd(walk2rob_rdaddr1);
    assign rob2walk_need_to_wb0 = mask[walk2rob_rdaddr0];
    assign rob2walk_need_to_wb1 = mask[walk2rob_rdaddr1];

    // Observed walk-slot bundle and its expected counterpart.
    logic [36:0] obs;
    assign obs = {walk2rob_rdaddr0, walk2rob_rdaddr1, walking_valid0, walking_valid1,
                  walking_lrd0, walking_prd0, walking_lrd1, walking_prd1, is_walking};

    function automatic logic [36:0] exp_vec(input logic [5:0] a0, input logic [5:0] a1,
                                            input logic v0, input logic v1);
        return {a0, a1, v0, v1,
                v0 ? m_lrd(a0) : 5'd0, v0 ? m_prd(a0) : 6'd0,
                v1 ? m_lrd(a1) : 5'd0, v1 ? m_prd(a1) : 6'd0, 1'b1};
    endfunction

    // Launch a flush from IDLE; returns #1 after the edge that enters ROLLBACK.
    task automatic start_flush(input logic [6:0] head, input logic [6:0] fl);
        flush_valid  = 1'b1;
        rob_head_ptr = head;
        flush_robptr = fl;
        @(posedge clock); #1;
        flush_valid  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({is_idle, is_rollingback, is_walking, walk_busy, walk_done, walking_valid0, walking_valid1} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b",
                     {is_idle, is_rollingback, is_walking, walk_busy, walk_done, walking_valid0, walking_valid1}, 7'b1000000);
        end
        checks++;
        if ({walk2rob_rdaddr0, walk2rob_rdaddr1, walking_lrd0, walking_prd0, walking_lrd1, walking_prd1} !== 34'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0",
                     {walk2rob_rdaddr0, walk2rob_rdaddr1, walking_lrd0, walking_prd0, walking_lrd1, walking_prd1});
        end
    endtask

    // head=10 flush=14: five entries, three walk cycles.
    task automatic test_basic();
        logic [5:0] a0;
        mask = '1;
        start_flush(7'd10, 7'd14);
        checks++;
        if ({is_idle, is_rollingback, is_walking, walk_busy} !== 4'b0101) begin
            failures++;
            $display("FAIL basic_rollback got=%b exp=0101", {is_idle, is_rollingback, is_walking, walk_busy});
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            a0 = 6'(10 + 2 * k);
            checks++;
            if (obs !== exp_vec(a0, a0 + 6'd1, 1'b1, k < 2)) begin
                failures++;
                $display("FAIL basic_walk%0d got=%h exp=%h", k, obs, exp_vec(a0, a0 + 6'd1, 1'b1, k < 2));
            end
        end
        @(posedge clock); #1;
        checks++;
        if ({is_idle, walk_done, walk_busy} !== 3'b110) begin
            failures++;
            $display("FAIL basic_done got=%b exp=110", {is_idle, walk_done, walk_busy});
        end
`ifdef ROB_WALK_PERF_EN
        checks++;
        if ({walk_cycle_cnt, flush_cnt} !== {32'd4, 32'd1}) begin
            failures++;
            $display("FAIL perf_cnt got=%0d/%0d exp=4/1", walk_cycle_cnt, flush_cnt);
        end
`endif
    endtask

    // Flush in the walk_done cycle must be accepted.
    task automatic test_back_to_back();
        start_flush(7'd30, 7'd31);
        checks++;
        if ({is_rollingback, walk_done} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_rollback got=%b exp=10", {is_rollingback, walk_done});
        end
        @(posedge clock); #1;
        checks++;
        if (obs !== exp_vec(6'd30, 6'd31, 1'b1, 1'b1)) begin
            failures++;
            $display("FAIL b2b_walk got=%h exp=%h", obs, exp_vec(6'd30, 6'd31, 1'b1, 1'b1));
        end
        @(posedge clock); #1;
        checks++;
        if ({is_idle, walk_done} !== 2'b11) begin
            failures++;
            $display("FAIL b2b_done got=%b exp=11", {is_idle, walk_done});
        end
        @(posedge clock); #1;
        checks++;
        if (walk_done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width got=%b exp=0", walk_done);
        end
    endtask

    task automatic test_need_wb();
        logic [5:0] a0;
        mask = '1;
        mask[11] = 1'b0;
        mask[13] = 1'b0;
        start_flush(7'd10, 7'd14);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            a0 = 6'(10 + 2 * k);
            checks++;
            if (obs !== exp_vec(a0, a0 + 6'd1, 1'b1, 1'b0)) begin
                failures++;
                $display("FAIL needwb_walk%0d got=%h exp=%h", k, obs, exp_vec(a0, a0 + 6'd1, 1'b1, 1'b0));
            end
        end
        @(posedge clock); #1;
        mask = '1;
    endtask

    task automatic test_wrap();
        logic [5:0] ea0 [2];
        ea0[0] = 6'd62;
        ea0[1] = 6'd0;
        start_flush(7'd62, 7'd65);
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            checks++;
            if (obs !== exp_vec(ea0[k], ea0[k] + 6'd1, 1'b1, 1'b1)) begin
                failures++;
                $display("FAIL wrap_walk%0d got=%h exp=%h", k, obs, exp_vec(ea0[k], ea0[k] + 6'd1, 1'b1, 1'b1));
            end
        end
        @(posedge clock); #1;
        checks++;
        if ({is_idle, walk_done} !== 2'b11) begin
            failures++;
            $display("FAIL wrap_done got=%b exp=11", {is_idle, walk_done});
        end
    endtask

    // head==flush: one entry; slot1 reads a writing entry but must stay invalid.
    task automatic test_single();
        start_flush(7'd20, 7'd20);
        @(posedge clock); #1;
        checks++;
        if (obs !== exp_vec(6'd20, 6'd21, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL single_walk got=%h exp=%h", obs, exp_vec(6'd20, 6'd21, 1'b1, 1'b0));
        end
        @(posedge clock); #1;
        checks++;
        if ({is_idle, walk_done} !== 2'b11) begin
            failures++;
            $display("FAIL single_done got=%b exp=11", {is_idle, walk_done});
        end
    endtask

    task automatic test_full();
        logic [5:0] a0;
        int         bad;
        bad = 0;
        start_flush(7'd0, 7'd63);
        for (int k = 0; k < 32; k++) begin
            @(posedge clock); #1;
            a0 = 6'(2 * k);
            checks++;
            if (obs !== exp_vec(a0, a0 + 6'd1, 1'b1, 1'b1)) begin
                failures++;
                bad++;
                if (bad < 4) $display("FAIL full_walk%0d got=%h exp=%h", k, obs, exp_vec(a0, a0 + 6'd1, 1'b1, 1'b1));
            end
        end
        @(posedge clock); #1;
        checks++;
        if ({is_idle, walk_done} !== 2'b11) begin
            failures++;
            $display("FAIL full_done got=%b exp=11", {is_idle, walk_done});
        end
    endtask

    // Flush requests during ROLLBACK and WALK must not disturb the walk.
    task automatic test_ignore_flush();
        start_flush(7'd40, 7'd43);
        flush_valid  = 1'b1;
        rob_head_ptr = 7'd0;
        flush_robptr = 7'd5;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            checks++;
            if (obs !== exp_vec(6'(40 + 2 * k), 6'(41 + 2 * k), 1'b1, 1'b1)) begin
                failures++;
                $display("FAIL ignore_walk%0d got=%h exp=%h", k, obs, exp_vec(6'(40 + 2 * k), 6'(41 + 2 * k), 1'b1, 1'b1));
            end
        end
        flush_valid = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({is_idle, walk_done} !== 2'b11) begin
            failures++;
            $display("FAIL ignore_done got=%b exp=11", {is_idle, walk_done});
        end
    endtask

    task automatic test_reset_mid_walk();
        start_flush(7'd0, 7'd63);
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({is_idle, is_rollingback, is_walking, walk_busy, walk_done, walking_valid0, walking_valid1} !== 7'b1000000) begin
            failures++;
            $display("FAIL midreset_state got=%b exp=%b",
                     {is_idle, is_rollingback, is_walking, walk_busy, walk_done, walking_valid0, walking_valid1}, 7'b1000000);
        end
        checks++;
        if ({walk2rob_rdaddr0, walk2rob_rdaddr1, walking_lrd0, walking_prd0, walking_lrd1, walking_prd1} !== 34'd0) begin
            failures++;
            $display("FAIL midreset_data got=%h exp=0",
                     {walk2rob_rdaddr0, walk2rob_rdaddr1, walking_lrd0, walking_prd0, walking_lrd1, walking_prd1});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({is_idle, walk_done, is_walking} !== 3'b100) begin
            failures++;
            $display("FAIL midreset_after got=%b exp=100", {is_idle, walk_done, is_walking});
        end
`ifdef ROB_WALK_PERF_EN
        checks++;
        if ({walk_cycle_cnt, flush_cnt} !== 64'd0) begin
            failures++;
            $display("FAIL perf_reset got=%0d/%0d exp=0/0", walk_cycle_cnt, flush_cnt);
        end
`endif
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        clock        = 1'b0;
        reset_n      = 1'b0;
        flush_valid  = 1'b0;
        flush_robptr = '0;
        rob_head_ptr = '0;
        mask         = '1;
        #12;
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        test_basic();
        test_back_to_back();
        test_need_wb();
        test_wrap();
        test_single();
        test_full();
        test_ignore_flush();
        test_reset_mid_walk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_walk_ctrl.md
Name: rob_walk_ctrl

Overview:
- Drives the rollback/walk interface of the speculative RAT after a flush.
- On a flush it runs one rollback cycle, in which the spec RAT reloads from the arch RAT.
- It then walks the surviving, uncommitted ROB entries from the ROB head up to and including the flushing instruction. Up to two entries per cycle are replayed as (lrd, prd) writes.
- Sits between the ROB (flush source, entry storage) and spec_rat / rename (walk sink, stall).

Parameters:
- ROB_DEPTH, 64, number of ROB entries (power of two).
- ROB_IDX_W, 6, log2(ROB_DEPTH), entry index width.
- ROB_PTR_W, 7, ROB_IDX_W+1, pointer width including wrap bit.
- LREG_W, 5, logical register index width.
- PREG_W, 6, physical register index width.

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- flush_valid  in  1  single-cycle flush request from ROB
- flush_robptr  in  ROB_PTR_W  pointer (with wrap bit) of the flushing instruction, which is kept
- rob_head_ptr  in  ROB_PTR_W  oldest uncommitted ROB pointer (with wrap bit)
- walk2rob_rdaddr0  out  ROB_IDX_W  ROB read index, slot 0
- walk2rob_rdaddr1  out  ROB_IDX_W  ROB read index, slot 1
- rob2walk_lrd0/lrd1  in  LREG_W  entry lrd, same-cycle combinational read
- rob2walk_prd0/prd1  in  PREG_W  entry prd
- rob2walk_need_to_wb0/1  in  1  entry writes a register
- is_idle  out  1  FSM in IDLE
- is_rollingback  out  1  rollback cycle
- is_walking  out  1  walk cycle
- walking_valid0/walking_valid1  out  1  slot writes spec RAT this cycle
- walking_lrd0/walking_lrd1  out  LREG_W  slot logical reg
- walking_prd0/walking_prd1  out  PREG_W  slot physical reg
- walk_busy  out  1  ~is_idle; stalls rename and commit
- walk_done  out  1  one-cycle pulse: recovery finished

Behaviour:
- Reset (async, any state): state=IDLE, is_idle=1, all other outputs 0, walk_ptr=0, walk_remain=0.
- States: IDLE, ROLLBACK, WALK. The state outputs are one-hot registered decodes.
- IDLE: flush_valid=1 captures walk_ptr<=rob_head_ptr and walk_remain<=((flush_robptr-rob_head_ptr) mod 2^ROB_PTR_W)+1, giving the range 1..ROB_DEPTH in ROB_PTR_W bits. Next state is ROLLBACK.
- ROLLBACK: lasts exactly one cycle with is_rollingback=1. Next state is WALK unconditionally. walk_remain>=1 always holds, because the flushing instruction is itself walked.
- WALK:
  - rdaddr0=walk_ptr[ROB_IDX_W-1:0] and rdaddr1=(walk_ptr+1) mod ROB_DEPTH, with natural index wrap 63->0.
  - walking_valid0 = (walk_remain>=1) & need_to_wb0.
  - walking_valid1 = (walk_remain>=2) & need_to_wb1.
  - walking_lrd/prd pass through the ROB data combinationally. When a slot's valid is 0, its lrd/prd are driven 0.
  - Each cycle: walk_ptr += min(2, walk_remain); walk_remain -= min(2, walk_remain).
  - When walk_remain<=2 in a WALK cycle, that cycle is the last and the next state is IDLE.
- Walk latency: 1 rollback cycle + ceil(count/2) walk cycles.
- walk_done: registered one-cycle pulse in the first IDLE cycle after WALK.
- A flush_valid in that same IDLE cycle is accepted normally.
- flush_valid while not IDLE is ignored. The ROB guarantees no flush during walk_busy.
- Program order is preserved: slot1 is younger than slot0. Same-lrd conflicts between the two slots are resolved by the spec RAT, where slot1 wins.
- walk_busy=1 from ROLLBACK through the last WALK cycle. The ROB must not advance rob_head_ptr during walk_busy. The block does not re-sample the head.

Optional Feature:
- Macro ROB_WALK_PERF_EN.
- Defined:
  - Adds output walk_cycle_cnt [31:0], which counts cycles with walk_busy=1 and saturates at 32'hFFFF_FFFF.
  - Adds output flush_cnt [31:0], which counts accepted flushes and also saturates.
  - Both are async reset to 0.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Test Plan:
- head=10, flush=14, all need_to_wb=1:
  - 1 rollback cycle, then 3 walk cycles.
  - rdaddr (10,11), (12,13), then (14,15) with valid1=0.
  - walk_done pulses in the next cycle.
- Wrap: head=7'd62, flush=7'd65:
  - count=4, walk cycles (62,63), (0,1), both valid.
  - Then IDLE.
- head=flush=7'd20: single walk cycle, valid0 per need_to_wb0, valid1=0, done the following cycle.
- Entries 11 and 13 with need_to_wb=0 (head=10, flush=14): the matching walking_valid=0 with lrd/prd=0; the others walk normally.
- Full ROB: head=7'd0, flush=7'd63, count=64. This takes 32 walk cycles.
- A second flush_valid mid-walk is ignored.
- reset_n low mid-walk returns to IDLE with all outputs at reset values.
- With ROB_WALK_PERF_EN, the count=5 case yields walk_cycle_cnt=4 and flush_cnt=1.
